mem_bus_ctrl: RTL and testbench
===============================

Name: mem_bus_ctrl

Overview:
- Sequences every picorv32 native-bus transaction onto the on-chip slaves: program ROM, work RAM, GPU char RAM and the LED register.
- Decodes the address and drives registered chip-selects and byte write enables.
- Inserts a per-region programmable wait-state count, then returns mem_ready and the registered read data.
- Sits between the CPU and the slaves in the top level, replacing the ad-hoc decode/ready logic there. It owns the LED register and a sticky bus-error flag.

Parameters:
- ROM_WAIT, 0, extra access cycles for ROM region (0..15)
- RAM_WAIT, 0, extra access cycles for RAM region (0..15)
- CHAR_WAIT, 1, extra access cycles for char RAM region (0..15)
- IO_WAIT, 0, extra access cycles for LED register (0..15)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- mem_valid  in  1  CPU request valid
- mem_addr  in  32  CPU byte address
- mem_wdata  in  32  CPU write data
- mem_wstrb  in  4  CPU byte strobes, 0 means read
- mem_ready  out  1  one-cycle transaction completion
- mem_rdata  out  32  registered read data
- rom_cs  out  1  ROM select
- ram_cs  out  1  work RAM select
- char_ram_cs  out  1  char RAM select
- dev_we  out  4  byte write enables to the selected RAM
- rom_q  in  32  ROM read data
- ram_q  in  32  RAM read data
- char_ram_q  in  32  char RAM read data
- led  out  8  LED register
- bus_err  out  1  sticky error flag

Behaviour:
- Clock port is clk; reset rst_n is synchronous and active-low. The block is single clock domain.
- Reset values: all outputs are 0. The FSM is in IDLE. led=0, bus_err=0, mem_rdata=0.
- Address decode is performed on mem_addr while in IDLE:
  - If mem_addr[31:16] != 0, the region is UNMAPPED.
  - Otherwise decode mem_addr[15:12]: 0=ROM, 1=RAM, 2=CHAR, 3=IO, else UNMAPPED.
- On entry to ACCESS, latch the region, the wait counter, and the read/write flag (mem_wstrb != 0).
- FSM states are IDLE, ACCESS, ACK:
  - IDLE: when mem_valid=1, go to ACCESS and load cnt=<region>_WAIT (UNMAPPED loads 0).
  - ACCESS: the selected cs is held high for every ACCESS cycle. Then:
    - If cnt != 0: cnt decrements.
    - If cnt == 0: capture mem_rdata from the selected source and go to ACK.
  - ACK: mem_ready=1 for exactly one cycle, cs=0, then go to IDLE. A new request can be accepted in IDLE no earlier than the cycle after ACK.
- Latency: with the valid sampled in cycle 0, ACCESS spans cycles 1..W+1 and mem_ready is high in cycle W+2. W=0 gives ready in cycle 2.
- dev_we equals the latched mem_wstrb in the first ACCESS cycle only, and is 0 in all other cycles. It is only driven for RAM/CHAR regions.
- The IO region writes the LED register in the first ACCESS cycle as led<=mem_wdata[7:0], only if wstrb[0]=1. An IO read returns {24'h0, led}.
- A ROM write produces no strobe; it completes normally and sets bus_err.
- UNMAPPED, read or write: no cs, rdata=0, completes with W=0, and sets bus_err.
- bus_err is cleared only by reset.
- mem_rdata holds its value until the next capture.
- If mem_valid drops during ACCESS (protocol violation): abort to IDLE with no mem_ready. cs and dev_we go to 0 the next cycle, and bus_err is set.
- Reset asserted mid-transaction forces IDLE on the next edge with all outputs at reset values. No mem_ready is issued.
- The counter is 4 bits wide; wait values above 15 are illegal, so wrap-around cannot occur.

Test Plan:
- Reset then idle: rst_n low for 3 cycles -> all outputs 0. With mem_valid=0 for 10 cycles -> mem_ready never asserts.
- RAM write then read: write addr 0x1004, wdata 0xDEADBEEF, wstrb 0xF, W=0.
  - ram_cs=1 in cycle 1; dev_we=0xF in cycle 1 only; mem_ready in cycle 2.
  - Read back 0x1004 -> mem_rdata=0xDEADBEEF with mem_ready.
- Char RAM wait states: read 0x2010 with CHAR_WAIT=1 -> char_ram_cs=1 in cycles 1-2, mem_ready in cycle 3, mem_rdata=char_ram_q.
- LED: write 0x3000, wdata 0x000000A5, wstrb 0x1 -> led=0xA5 after cycle 1. Read 0x3000 -> mem_rdata=0x000000A5.
- Errors:
  - Read 0x00015000 -> mem_ready in cycle 2, mem_rdata=0, bus_err=1, no cs.
  - Write 0x0000 -> no dev_we, bus_err remains 1 until reset.
- Abort/reset: with CHAR_WAIT=3, pull rst_n low in cycle 2 -> next cycle all cs=0, mem_ready never asserts. Drop mem_valid in ACCESS instead -> IDLE, no ready, bus_err=1.

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// Native-bus sequencer for picorv32: decodes ROM/RAM/char RAM/LED regions,
// drives registered selects and strobes, inserts per-region wait states.
module mem_bus_ctrl #(
  parameter int unsigned ROM_WAIT  = 0,
  parameter int unsigned RAM_WAIT  = 0,
  parameter int unsigned CHAR_WAIT = 1,
  parameter int unsigned IO_WAIT   = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        rom_cs,
  output logic        ram_cs,
  output logic        char_ram_cs,
  output logic [3:0]  dev_we,
  input  logic [31:0] rom_q,
  input  logic [31:0] ram_q,
  input  logic [31:0] char_ram_q,
  output logic [7:0]  led,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
  typedef enum logic [2:0] {REG_ROM, REG_RAM, REG_CHAR, REG_IO, REG_NONE} region_t;

  state_t      state_q, state_d;
  region_t     region_q, region_d, region_dec;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic        first_q, first_d;
  logic        io_we_q, io_we_d;
  logic        ready_d, rom_cs_d, ram_cs_d, char_cs_d, err_d;
  logic [3:0]  dev_we_d;
  logic [31:0] rdata_d;
  logic [7:0]  led_d;

  logic unused_bits;
  assign unused_bits = &{1'b0, mem_addr[11:0], mem_wdata[31:8]};

  function automatic region_t decode(input logic [31:0] a);
    if (a[31:16] != 16'h0) return REG_NONE;
    case (a[15:12])
      4'h0:    return REG_ROM;
      4'h1:    return REG_RAM;
      4'h2:    return REG_CHAR;
      4'h3:    return REG_IO;
      default: return REG_NONE;
    endcase
  endfunction

  function automatic logic [3:0] wait_of(input region_t r);
    case (r)
      REG_ROM:  return 4'(ROM_WAIT);
      REG_RAM:  return 4'(RAM_WAIT);
      REG_CHAR: return 4'(CHAR_WAIT);
      REG_IO:   return 4'(IO_WAIT);
      default:  return 4'h0;
    endcase
  endfunction

  assign region_dec = decode(mem_addr);

  always_comb begin
    state_d   = state_q;
    region_d  = region_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    io_we_d   = io_we_q;
    first_d   = 1'b0;
    ready_d   = 1'b0;
    rom_cs_d  = 1'b0;
    ram_cs_d  = 1'b0;
    char_cs_d = 1'b0;
    dev_we_d  = 4'h0;
    rdata_d   = mem_rdata;
    led_d     = led;
    err_d     = bus_err;
    case (state_q)
      IDLE: begin
        if (mem_valid) begin
          state_d   = ACCESS;
          region_d  = region_dec;
          cnt_d     = wait_of(region_dec);
          wr_d      = (mem_wstrb != 4'h0);
          io_we_d   = mem_wstrb[0];
          first_d   = 1'b1;
          rom_cs_d  = (region_dec == REG_ROM);
          ram_cs_d  = (region_dec == REG_RAM);
          char_cs_d = (region_dec == REG_CHAR);
          if (region_dec == REG_RAM || region_dec == REG_CHAR) dev_we_d = mem_wstrb;
          // ROM writes and unmapped accesses still complete but are flagged
          if (region_dec == REG_NONE || (region_dec == REG_ROM && mem_wstrb != 4'h0))
            err_d = 1'b1;
        end
      end
      ACCESS: begin
        if (!mem_valid) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          if (first_q && region_q == REG_IO && wr_q && io_we_q) led_d = mem_wdata[7:0];
          if (cnt_q != 4'h0) begin
            cnt_d     = cnt_q - 4'h1;
            rom_cs_d  = rom_cs;
            ram_cs_d  = ram_cs;
            char_cs_d = char_ram_cs;
          end else begin
            case (region_q)
              REG_ROM:  rdata_d = rom_q;
              REG_RAM:  rdata_d = ram_q;
              REG_CHAR: rdata_d = char_ram_q;
              REG_IO:   rdata_d = {24'h0, led};
              default:  rdata_d = 32'h0;
            endcase
            ready_d = 1'b1;
            state_d = ACK;
          end
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---- registered outputs and transaction context ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      region_q    <= REG_NONE;
      cnt_q       <= 4'h0;
      wr_q        <= 1'b0;
      first_q     <= 1'b0;
      io_we_q     <= 1'b0;
      mem_ready   <= 1'b0;
      mem_rdata   <= 32'h0;
      rom_cs      <= 1'b0;
      ram_cs      <= 1'b0;
      char_ram_cs <= 1'b0;
      dev_we      <= 4'h0;
      led         <= 8'h0;
      bus_err     <= 1'b0;
    end else begin
      region_q    <= region_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      first_q     <= first_d;
      io_we_q     <= io_we_d;
      mem_ready   <= ready_d;
      mem_rdata   <= rdata_d;
      rom_cs      <= rom_cs_d;
      ram_cs      <= ram_cs_d;
      char_ram_cs <= char_cs_d;
      dev_we      <= dev_we_d;
      led         <= led_d;
      bus_err     <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: directed scenarios plus random transactions
// checked against a transaction-level model of the memory map.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        rom_cs, ram_cs, char_ram_cs;
  logic [3:0]  dev_we;
  logic [31:0] rom_q, ram_q, char_ram_q;
  logic [7:0]  led;
  logic        bus_err;

  int total = 0;
  int bad   = 0;

  localparam int ROM_W = 2, RAM_W = 0, CHAR_W = 1, IO_W = 0;

  mem_bus_ctrl #(.ROM_WAIT(ROM_W), .RAM_WAIT(RAM_W), .CHAR_WAIT(CHAR_W), .IO_WAIT(IO_W)) dut (
    .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .rom_cs(rom_cs), .ram_cs(ram_cs), .char_ram_cs(char_ram_cs),
    .dev_we(dev_we), .rom_q(rom_q), .ram_q(ram_q), .char_ram_q(char_ram_q),
    .led(led), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Slave memories (asynchronous read, byte-lane write on the clock edge)
  bit [31:0] ram_mem  [1024];
  bit [31:0] char_mem [1024];

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[15:0]};
  endfunction

  assign rom_q      = rom_fn(mem_addr);
  assign ram_q      = ram_mem[mem_addr[11:2]];
  assign char_ram_q = char_mem[mem_addr[11:2]];

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_cs && dev_we[b])      ram_mem[mem_addr[11:2]][8*b +: 8]  <= mem_wdata[8*b +: 8];
      if (char_ram_cs && dev_we[b]) char_mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // Reference model state
  bit [31:0] ref_ram  [1024];
  bit [31:0] ref_char [1024];
  logic [7:0] ref_led;
  logic       ref_err;

  function automatic int region_of(input logic [31:0] a);
    if (a[31:16] != 16'h0) return 4;
    if (a[15:12] <= 4'h3) return int'(a[15:12]);
    return 4;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] ws);
    logic [31:0] v;
    v = old;
    for (int b = 0; b < 4; b++) if (ws[b]) v[8*b +: 8] = wd[8*b +: 8];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cs_vec();
    return {29'h0, rom_cs, ram_cs, char_ram_cs};
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdy"},   {31'h0, mem_ready}, 32'h0);
    chk({tag, "_cs"},    cs_vec(), 32'h0);
    chk({tag, "_we"},    {28'h0, dev_we}, 32'h0);
    chk({tag, "_rdata"}, mem_rdata, 32'h0);
    chk({tag, "_led"},   {24'h0, led}, 32'h0);
    chk({tag, "_err"},   {31'h0, bus_err}, 32'h0);
  endtask

  // One full transaction; called and returns at a negative edge with the DUT idle.
  task automatic xact(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    int r, w;
    logic [31:0] exp_cs, exp_we, exp_rd;
    r = region_of(a);
    case (r)
      0: begin w = ROM_W;  exp_cs = 32'h4; end
      1: begin w = RAM_W;  exp_cs = 32'h2; end
      2: begin w = CHAR_W; exp_cs = 32'h1; end
      3: begin w = IO_W;   exp_cs = 32'h0; end
      default: begin w = 0; exp_cs = 32'h0; end
    endcase
    exp_we = (r == 1 || r == 2) ? {28'h0, ws} : 32'h0;
    case (r)
      0: exp_rd = rom_fn(a);
      1: exp_rd = ref_ram[a[11:2]];
      2: exp_rd = ref_char[a[11:2]];
      3: exp_rd = {24'h0, ref_led};
      default: exp_rd = 32'h0;
    endcase
    if (ws != 4'h0) begin
      if (r == 1) ref_ram[a[11:2]]  = merge(ref_ram[a[11:2]], wd, ws);
      if (r == 2) ref_char[a[11:2]] = merge(ref_char[a[11:2]], wd, ws);
      if (r == 3 && ws[0]) ref_led = wd[7:0];
      if (r == 0) ref_err = 1'b1;
    end
    if (r == 4) ref_err = 1'b1;

    mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
    for (int k = 1; k <= w + 2; k++) begin
      @(negedge clk);
      if (k <= w + 1) begin
        chk("access_cs",  cs_vec(), exp_cs);
        chk("access_we",  {28'h0, dev_we}, (k == 1) ? exp_we : 32'h0);
        chk("access_rdy", {31'h0, mem_ready}, 32'h0);
      end else begin
        chk("ack_rdy", {31'h0, mem_ready}, 32'h1);
        chk("ack_cs",  cs_vec(), 32'h0);
        chk("ack_we",  {28'h0, dev_we}, 32'h0);
        if (ws == 4'h0) chk("ack_rdata", mem_rdata, exp_rd);
        chk("ack_led", {24'h0, led}, {24'h0, ref_led});
        chk("ack_err", {31'h0, bus_err}, {31'h0, ref_err});
      end
    end
    mem_valid = 1'b0; mem_wstrb = 4'h0;
    @(negedge clk);
    chk("post_rdy", {31'h0, mem_ready}, 32'h0);
  endtask

  initial begin
    logic [31:0] a, wd;
    logic [3:0]  ws;
    int          sel;
    rst_n = 1'b0; mem_valid = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0;
    ref_led = 8'h0; ref_err = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_rdy", {31'h0, mem_ready}, 32'h0);
    end

    xact(32'h0000_1004, 32'hDEAD_BEEF, 4'hF);
    xact(32'h0000_1004, 32'h0, 4'h0);
    chk("ram_readback", mem_rdata, 32'hDEAD_BEEF);
    xact(32'h0000_2010, 32'h1234_5678, 4'hF);
    xact(32'h0000_2010, 32'h0, 4'h0);
    chk("char_readback", mem_rdata, 32'h1234_5678);
    xact(32'h0000_3000, 32'h0000_00A5, 4'h1);
    chk("led_write", {24'h0, led}, 32'hA5);
    xact(32'h0000_3000, 32'h0, 4'h0);
    chk("led_read", mem_rdata, 32'hA5);
    xact(32'h0001_5000, 32'h0, 4'h0);
    chk("unmapped_err", {31'h0, bus_err}, 32'h1);
    xact(32'h0000_0000, 32'hFFFF_FFFF, 4'hF);
    chk("rom_write_err", {31'h0, bus_err}, 32'h1);

    // Drop mem_valid in the first ACCESS cycle of a ROM read
    mem_valid = 1'b1; mem_addr = 32'h0000_0100; mem_wstrb = 4'h0;
    @(negedge clk);
    chk("abort_cs_on", cs_vec(), 32'h4);
    mem_valid = 1'b0;
    @(negedge clk);
    chk("abort_cs_off", cs_vec(), 32'h0);
    chk("abort_err", {31'h0, bus_err}, 32'h1);
    ref_err = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("abort_rdy", {31'h0, mem_ready}, 32'h0);
      @(negedge clk);
    end

    // Reset in the second ACCESS cycle of a char RAM read
    mem_valid = 1'b1; mem_addr = 32'h0000_2010; mem_wstrb = 4'h0;
    @(negedge clk);
    chk("rstmid_cs", cs_vec(), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("rstmid");
    rst_n = 1'b1; mem_valid = 1'b0;
    ref_led = 8'h0; ref_err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstmid_rdy", {31'h0, mem_ready}, 32'h0);
    end

    for (int n = 0; n < 300; n++) begin
      sel = int'($urandom_range(0, 9));
      a = {20'h0, $urandom_range(0, 4095)} & 32'hFFFF_FFFC;
      case (sel)
        0, 1:    a[15:12] = 4'h0;
        2, 3:    a[15:12] = 4'h1;
        4, 5:    a[15:12] = 4'h2;
        6, 7:    a[15:12] = 4'h3;
        8:       a[15:12] = 4'(4 + $urandom_range(0, 11));
        default: begin a[15:12] = 4'(int'($urandom_range(0, 3))); a[31:16] = 16'(1 + $urandom_range(0, 65534)); end
      endcase
      wd = $urandom;
      ws = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'(1 + $urandom_range(0, 14));
      xact(a, wd, ws);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
